// File: rtl/bmc_array.sv
// bmc_array: pipelined branch metric array for the Viterbi decoder.
//
// Computes, for each of NUM_BMC trellis branch units, the soft-decision
// distance between the received symbol pair and the expected bit pair on
// path 0 and path 1. Unit i on path 0 expects (0, INV_MASK[i]); path 1
// expects the complement. Two register stages (S1: symbols + per-bit
// distances, S2: summed metrics) with valid/ready flow control.
//
// Optional build macro: BMC_ERASURE_EN adds rx_erase; an erased bit scores
// distance 0 on both paths of every unit (punctured codes).
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid / in_ready   input handshake for rx_sym / in_last (/ rx_erase)
//   rx_sym                [SOFT_W-1:0] = bit 0, [2*SOFT_W-1:SOFT_W] = bit 1
//   rx_erase              per-bit erasure flags (BMC_ERASURE_EN only)
//   in_last               final symbol pair of the frame
//   out_valid / out_ready output handshake for metrics and out_last
//   path_0_bmc/path_1_bmc unit i metric at [i*(SOFT_W+1) +: SOFT_W+1]
//   out_last              in_last carried through the pipeline
//   sym_count             symbols delivered in the current frame (saturating)

module bmc_array #(
    parameter int                 SOFT_W   = 1,
    parameter int                 NUM_BMC  = 8,
    parameter logic [NUM_BMC-1:0] INV_MASK = NUM_BMC'(8'b0110_0110),
    parameter int                 CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2*SOFT_W-1:0]          rx_sym,
`ifdef BMC_ERASURE_EN
    input  logic [1:0]                   rx_erase,
`endif
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_BMC*(SOFT_W+1)-1:0] path_0_bmc,
    output logic [NUM_BMC*(SOFT_W+1)-1:0] path_1_bmc,
    output logic                         out_last,
    output logic [CNT_W-1:0]             sym_count
);

    localparam int                MW      = SOFT_W + 1;
    localparam logic [SOFT_W-1:0] MAX     = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic              s1_v;
    logic [SOFT_W-1:0] s1_s0;
    logic [SOFT_W-1:0] s1_s1;
    logic              s1_last;
`ifdef BMC_ERASURE_EN
    logic [1:0]        s1_erase;
`endif
    logic              s2_v;
    logic              s2_adv;
    logic              clr_pend;

    // Per-bit distances against an expected 0 and an expected 1.
    logic [SOFT_W-1:0] d0_zero, d0_one, d1_zero, d1_one;
    logic [NUM_BMC*MW-1:0] m0, m1;

    assign s2_adv    = !s2_v || out_ready;
    assign in_ready  = !s1_v || s2_adv;
    assign out_valid = s2_v;

    always_comb begin
        d0_zero = s1_s0;
        d0_one  = MAX - s1_s0;
        d1_zero = s1_s1;
        d1_one  = MAX - s1_s1;
`ifdef BMC_ERASURE_EN
        if (s1_erase[0]) begin
            d0_zero = '0;
            d0_one  = '0;
        end
        if (s1_erase[1]) begin
            d1_zero = '0;
            d1_one  = '0;
        end
`endif
    end

    always_comb begin
        m0 = '0;
        m1 = '0;
        for (int i = 0; i < NUM_BMC; i++) begin
            m0[i*MW +: MW] = MW'(d0_zero) + (INV_MASK[i] ? MW'(d1_one)  : MW'(d1_zero));
            m1[i*MW +: MW] = MW'(d0_one)  + (INV_MASK[i] ? MW'(d1_zero) : MW'(d1_one));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v       <= 1'b0;
            s1_s0      <= '0;
            s1_s1      <= '0;
            s1_last    <= 1'b0;
`ifdef BMC_ERASURE_EN
            s1_erase   <= '0;
`endif
            s2_v       <= 1'b0;
            path_0_bmc <= '0;
            path_1_bmc <= '0;
            out_last   <= 1'b0;
            sym_count  <= '0;
            clr_pend   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_s0   <= rx_sym[SOFT_W-1:0];
                    s1_s1   <= rx_sym[2*SOFT_W-1:SOFT_W];
                    s1_last <= in_last;
`ifdef BMC_ERASURE_EN
                    s1_erase <= rx_erase;
`endif
                end
            end

            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    path_0_bmc <= m0;
                    path_1_bmc <= m1;
                    out_last   <= s1_last;
                end
            end

            // The count shows the full frame length for one cycle after the
            // last transfer, then clears; a transfer in that cycle starts the
            // next frame at 1.
            if (out_valid && out_ready) begin
                if (clr_pend)
                    sym_count <= CNT_W'(1);
                else if (sym_count != CNT_MAX)
                    sym_count <= sym_count + CNT_W'(1);
                clr_pend <= out_last;
            end else if (clr_pend) begin
                sym_count <= '0;
                clr_pend  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bmc_array.sv
// Directed bench for bmc_array: a hard-decision instance (SOFT_W=1) and a
// soft-decision instance (SOFT_W=3, 2-bit counter to reach saturation)
// share clock, reset and handshake controls.

module tb_bmc_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_last, out_ready;

    logic [1:0]  rx_h;
    logic        in_ready_h, out_valid_h, last_h;
    logic [15:0] p0_h, p1_h, cnt_h;

    logic [5:0]  rx_s;
    logic        in_ready_s, out_valid_s, last_s;
    logic [31:0] p0_s, p1_s;
    logic [1:0]  cnt_s;

`ifdef BMC_ERASURE_EN
    logic [1:0] er_h, er_s;
`endif

    int total = 0;
    int bad   = 0;

    bmc_array #(.SOFT_W(1)) dut_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h),
        .rx_sym(rx_h),
`ifdef BMC_ERASURE_EN
        .rx_erase(er_h),
`endif
        .in_last(in_last), .out_valid(out_valid_h), .out_ready(out_ready),
        .path_0_bmc(p0_h), .path_1_bmc(p1_h), .out_last(last_h), .sym_count(cnt_h)
    );

    bmc_array #(.SOFT_W(3), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .rx_sym(rx_s),
`ifdef BMC_ERASURE_EN
        .rx_erase(er_s),
`endif
        .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready),
        .path_0_bmc(p0_s), .path_1_bmc(p1_s), .out_last(last_s), .sym_count(cnt_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference metric vector for the default mask, packed like the DUT.
    function automatic logic [63:0] ref_bmc(input int w, input int s0, input int s1, input bit path);
        logic [7:0]  mask = 8'b0110_0110;
        int          mx   = (1 << w) - 1;
        logic [63:0] r    = '0;
        for (int i = 0; i < 8; i++) begin
            bit e0 = path;
            bit e1 = mask[i] ^ path;
            int d0 = e0 ? (mx - s0) : s0;
            int d1 = e1 ? (mx - s1) : s1;
            r |= 64'(d0 + d1) << (i * (w + 1));
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        rx_h = '0; rx_s = '0;
`ifdef BMC_ERASURE_EN
        er_h = '0; er_s = '0;
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] expq[$];
        int sent, got;
        bit acc, xfer;

        // Reset state
        do_reset();
        chk("rst_out_valid", out_valid_h, 0);
        chk("rst_sym_count", cnt_h, 0);
        chk("rst_path0", p0_h, 0);
        chk("rst_path1", p1_h, 0);
        chk("rst_out_last", last_h, 0);
        chk("rst_in_ready", in_ready_h, 1);

        // Hard rx=00 and soft s0=5,s1=2 in the same cycle
        rx_h = 2'b00; rx_s = {3'd2, 3'd5}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_not_yet", out_valid_h, 0);
        tick();
        chk("lat_valid", out_valid_h, 1);
        chk("hard_u0_p0", p0_h[1:0], 0);
        chk("hard_u0_p1", p1_h[1:0], 2);
        chk("hard_u1_p0", p0_h[3:2], 1);
        chk("hard_u1_p1", p1_h[3:2], 1);
        chk("hard_vec_p0", p0_h, ref_bmc(1, 0, 0, 0));
        chk("hard_vec_p1", p1_h, ref_bmc(1, 0, 0, 1));
        chk("soft_u0_p0", p0_s[3:0], 7);
        chk("soft_u0_p1", p1_s[3:0], 7);
        chk("soft_u1_p0", p0_s[7:4], 10);
        chk("soft_u1_p1", p1_s[7:4], 4);
        chk("soft_vec_p0", p0_s, ref_bmc(3, 5, 2, 0));
        chk("soft_vec_p1", p1_s, ref_bmc(3, 5, 2, 1));
        tick();
        chk("after_xfer_valid", out_valid_h, 0);
        chk("after_xfer_count", cnt_h, 1);

        // Backpressure: 6 pairs, out_ready pattern 1,0,0 repeating
        do_reset();
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            out_ready = (cyc % 3 == 0);
            in_valid  = (sent < 6);
            rx_s      = {3'd0, 3'(sent + 1)};
            #1;
            chk("bp_in_ready", in_ready_s, ((sent - got) == 2 && !out_ready) ? 0 : 1);
            acc  = in_valid && in_ready_s;
            xfer = out_valid_s && out_ready;
            if (out_valid_s) begin
                if (expq.size() > 0) chk("bp_data", p0_s, expq[0]);
                else                 chk("bp_spurious_valid", out_valid_s, 0);
            end
            tick();
            if (acc) begin
                expq.push_back(ref_bmc(3, sent + 1, 0, 0));
                sent++;
            end
            if (xfer && expq.size() > 0) begin
                void'(expq.pop_front());
                got++;
            end
        end
        in_valid = 1'b0;
        chk("bp_delivered", got, 6);
        chk("bp_sent", sent, 6);

        // Frame of 4 with in_last on the 4th; soft instance saturates at 3
        do_reset();
        in_valid = 1'b1; rx_h = 2'b01;
        tick();
        rx_h = 2'b10;
        tick();
        chk("frm_valid", out_valid_h, 1);
        chk("frm_cnt0", cnt_h, 0);
        chk("frm_last_early", last_h, 0);
        rx_h = 2'b11;
        tick();
        chk("frm_cnt1", cnt_h, 1);
        rx_h = 2'b00; in_last = 1'b1;
        tick();
        chk("frm_cnt2", cnt_h, 2);
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        chk("frm_cnt3", cnt_h, 3);
        chk("frm_out_last", last_h, 1);
        chk("frm_soft_cnt3", cnt_s, 3);
        tick();
        chk("frm_cnt4", cnt_h, 4);
        chk("frm_soft_sat", cnt_s, 3);
        chk("frm_drained", out_valid_h, 0);
        tick();
        chk("frm_cnt_clr", cnt_h, 0);
        chk("frm_soft_cnt_clr", cnt_s, 0);

        // Reset with both stages full
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0; rx_h = 2'b01;
        tick();
        rx_h = 2'b10;
        tick();
        chk("full_in_ready", in_ready_h, 0);
        chk("full_valid", out_valid_h, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("mrst_valid", out_valid_h, 0);
        chk("mrst_count", cnt_h, 0);
        chk("mrst_p0", p0_h, 0);
        chk("mrst_p1", p1_h, 0);
        chk("mrst_last", last_h, 0);
        chk("mrst_in_ready", in_ready_h, 1);
        out_ready = 1'b1; in_valid = 1'b1; rx_h = 2'b11;
        tick();
        in_valid = 1'b0;
        chk("mrst_lat1", out_valid_h, 0);
        tick();
        chk("mrst_lat2", out_valid_h, 1);
        chk("mrst_p0_data", p0_h, ref_bmc(1, 1, 1, 0));
        chk("mrst_p1_data", p1_h, ref_bmc(1, 1, 1, 1));

`ifdef BMC_ERASURE_EN
        do_reset();
        rx_h = 2'b11; er_h = 2'b10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; er_h = 2'b00;
        tick();
        chk("era_valid", out_valid_h, 1);
        chk("era_u0_p0", p0_h[1:0], 1);
        chk("era_u0_p1", p1_h[1:0], 0);
        chk("era_u1_p0", p0_h[3:2], 1);
        chk("era_u1_p1", p1_h[3:2], 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
